sisc_exec_ctrl: RTL and testbench
=================================

# sisc_exec_ctrl

Combined execution/control block of the SISC processor: multicycle control FSM, 32-bit ALU and branch-target calculator in one unit. Sits between the instruction register and the datapath. It decodes the latched instruction and drives register-file write, PC, IR and status-register strobes, and produces ALU results, CC flags and branch addresses. Register file, status register, PC, IR and instruction memory are external.

## Interface
- No parameters; widths fixed (data 32, PC 16).
- clk  in  1  rising-edge clock
- rst_f  in  1  reset; synchronous, active-high
- instr  in  32  IR contents; opcode [31:28], mm/funct [27:24], rd [23:20], rs [19:16], rt [15:12], imm [15:0]
- rega  in  32  rs operand
- regb  in  32  rt operand
- stat  in  4  status register {C,N,V,Z} = [3:0]
- pc_in  in  16  current PC (already incremented by fetch)
- alu_out  out  32  ALU result
- alu_sts  out  4  computed {C,N,V,Z}
- stat_en  out  4  per-bit status-register write enable
- rf_we, wb_sel  out  1  register write enable; writeback select (0 = alu_out)
- pc_rst, pc_write, pc_sel, ir_load  out  1  PC reset; PC load; PC source (0 = PC+1, 1 = br_addr); IR load
- br_sel  out  1  1 = absolute target
- br_addr  out  16  branch target

## Operation
- Opcodes: 0000 NOP, 0001 ALU reg-reg (B = regb), 0010 ALU reg-imm (B = sign-extended imm), 0100 BRA, 0101 BRR, 0110 BNE, 0111 BNR, 1111 HLT; others act as NOP.
- ALU funct (mm): 0000 NOT A; 0001 ADD; 0010 SUB (A+~B+1); 0011 ADC (A+B+stat[3]); 0100 AND; 0101 OR; 0110 XOR; 0111 SHL by B[4:0]; 1000 SHR logical; 1001 ROL; 1010 ROR; 1011 PASS B; others: result 0, stat_en 0000.
- Flags: N = res[31]; Z = (res == 0). Arithmetic: C = bit 32 of 33-bit sum, V = signed overflow, stat_en 1111. Logic/NOT/PASS: stat_en 0101. Shifts/rotates: C = last bit shifted out (0 if amount 0), stat_en 1101.
- Branch condition: BRA/BRR taken if mm == 0 or (mm & stat) != 0; BNE/BNR taken if (mm & stat) == 0.
- br_sel = 1 for BRA/BNE. br_addr = br_sel ? imm : pc_in + imm, modulo 2^16, combinational.

## Timing
- FSM states: START0 -> START1 -> FETCH -> DECODE -> EXECUTE -> MEM -> WRITEBACK -> FETCH; HALT is absorbing.
- START0: pc_rst=1. START1: all strobes 0.
- FETCH: ir_load=1, pc_write=1, pc_sel=0.
- DECODE: taken branch drives pc_sel=1, pc_write=1. HLT goes to HALT.
- EXECUTE: alu_out/alu_sts valid; stat_en nonzero only here and only for opcodes 0001/0010.
- MEM: idle.
- WRITEBACK: rf_we=1 and wb_sel=0 for opcodes 0001/0010.
- One instruction per 5 cycles.
- Reset: edge with rst_f=1 forces START0. While rst_f=1, pc_rst=1 and rf_we, pc_write, ir_load, stat_en are forced 0 combinationally, including mid-instruction; an interrupted writeback is dropped.
- Reset values: all outputs 0 except pc_rst=1. alu_out, alu_sts and br_addr follow their inputs combinationally.
- HALT: all strobes 0 until reset.

## Configuration
- SISC_ROTATE_EN: defined gives ROL/ROR as above. Undefined makes funct 1001/1010 undefined codes: result 0, stat_en 0000.

## Structure
- Package sisc_pkg holds opcode and funct constants, the FSM state enum, and status bit indices C=3, N=2, V=1, Z=0.
- Sub-module sisc_alu: the combinational ALU (operands, funct, carry-in -> result, flags, flag enables).
- FSM, branch condition and target logic live in the top.

## Test plan
- Reset: rst_f=1 for 2 cycles -> pc_rst=1, all other strobes 0. After release: START1, then ir_load=1 and pc_write=1 one cycle later.
- ADD overflow: instr 0x11312000, rega=0x7FFFFFFF, regb=1 -> EXECUTE: alu_out=0x80000000, alu_sts=0110, stat_en=1111. WRITEBACK: rf_we=1.
- SUB to zero: instr 0x12312000, rega=regb=5 -> alu_out=0, alu_sts=1001.
- BRR: instr 0x51000005, pc_in=0x0010, stat=0001 -> DECODE: br_sel=0, br_addr=0x0015, pc_sel=1, pc_write=1. With stat=0000: pc_write=0.
- BNE absolute: instr 0x61000040, stat=0000 -> br_sel=1, br_addr=0x0040, taken. Reset asserted in EXECUTE of a following ADD -> no rf_we.
- HLT: instr 0xF0000000 -> no ir_load or pc_write for 20 cycles. Reset then restarts from START0.

Source files
------------

// File: rtl/sisc_pkg.sv
// ============================================================================
//  Module      : sisc_pkg
//  Description : Shared opcode/funct encodings, FSM states and status-bit
//                indices for the SISC execution/control block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sisc_pkg;

    localparam logic [3:0] C_OP_NOP    = 4'b0000;
    localparam logic [3:0] C_OP_ALU_RR = 4'b0001;
    localparam logic [3:0] C_OP_ALU_RI = 4'b0010;
    localparam logic [3:0] C_OP_BRA    = 4'b0100;
    localparam logic [3:0] C_OP_BRR    = 4'b0101;
    localparam logic [3:0] C_OP_BNE    = 4'b0110;
    localparam logic [3:0] C_OP_BNR    = 4'b0111;
    localparam logic [3:0] C_OP_HLT    = 4'b1111;

    localparam logic [3:0] C_FN_NOT  = 4'b0000;
    localparam logic [3:0] C_FN_ADD  = 4'b0001;
    localparam logic [3:0] C_FN_SUB  = 4'b0010;
    localparam logic [3:0] C_FN_ADC  = 4'b0011;
    localparam logic [3:0] C_FN_AND  = 4'b0100;
    localparam logic [3:0] C_FN_OR   = 4'b0101;
    localparam logic [3:0] C_FN_XOR  = 4'b0110;
    localparam logic [3:0] C_FN_SHL  = 4'b0111;
    localparam logic [3:0] C_FN_SHR  = 4'b1000;
    localparam logic [3:0] C_FN_ROL  = 4'b1001;
    localparam logic [3:0] C_FN_ROR  = 4'b1010;
    localparam logic [3:0] C_FN_PASS = 4'b1011;

    localparam int C_STS_C = 3;
    localparam int C_STS_N = 2;
    localparam int C_STS_V = 1;
    localparam int C_STS_Z = 0;

    typedef enum logic [2:0] {
        ST_START0    = 3'd0,
        ST_START1    = 3'd1,
        ST_FETCH     = 3'd2,
        ST_DECODE    = 3'd3,
        ST_EXECUTE   = 3'd4,
        ST_MEM       = 3'd5,
        ST_WRITEBACK = 3'd6,
        ST_HALT      = 3'd7
    } state_t;

endpackage

`default_nettype wire

// File: rtl/sisc_exec_ctrl_if.sv
// ============================================================================
//  Module      : sisc_exec_ctrl_if
//  Description : Datapath-side bundle of the SISC execution/control block.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface sisc_exec_ctrl_if;
    logic [31:0] instr;
    logic [31:0] rega;
    logic [31:0] regb;
    logic [3:0]  stat;
    logic [15:0] pc_in;
    logic [31:0] alu_out;
    logic [3:0]  alu_sts;
    logic [3:0]  stat_en;
    logic        rf_we;
    logic        wb_sel;
    logic        pc_rst;
    logic        pc_write;
    logic        pc_sel;
    logic        ir_load;
    logic        br_sel;
    logic [15:0] br_addr;

    modport master (
        output instr, rega, regb, stat, pc_in,
        input  alu_out, alu_sts, stat_en, rf_we, wb_sel,
        input  pc_rst, pc_write, pc_sel, ir_load, br_sel, br_addr
    );

    modport slave (
        input  instr, rega, regb, stat, pc_in,
        output alu_out, alu_sts, stat_en, rf_we, wb_sel,
        output pc_rst, pc_write, pc_sel, ir_load, br_sel, br_addr
    );
endinterface

`default_nettype wire

// File: rtl/sisc_alu.sv
// ============================================================================
//  Module      : sisc_alu
//  Description : Combinational 32-bit SISC ALU producing result, {C,N,V,Z}
//                and per-flag update enables. ROL/ROR exist only when
//                SISC_ROTATE_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sisc_alu
    import sisc_pkg::*;
(
    input  wire logic [31:0] i_a,
    input  wire logic [31:0] i_b,
    input  wire logic [3:0]  i_funct,
    input  wire logic        i_cin,
    output logic      [31:0] o_result,
    output logic      [3:0]  o_flags,
    output logic      [3:0]  o_flag_en
);

    logic [31:0] w_bb;
    logic        w_ci;
    logic [32:0] w_sum;
    logic [5:0]  w_sh;
    logic [5:0]  w_sh_inv;
    logic [31:0] w_lo;
    logic [31:0] w_hi;
    logic        w_c;
    logic        w_v;

    assign w_sh     = {1'b0, i_b[4:0]};
    assign w_sh_inv = 6'd32 - w_sh;
    // Complementary shifts: w_lo[0] / w_hi[31] are the last bits out of
    // a left / right shift, and both are zero when the amount is zero.
    assign w_lo     = i_a >> w_sh_inv;
    assign w_hi     = i_a << w_sh_inv;

    always_comb begin
        w_bb = i_b;
        w_ci = 1'b0;
        if (i_funct == C_FN_SUB) begin
            w_bb = ~i_b;
            w_ci = 1'b1;
        end else if (i_funct == C_FN_ADC) begin
            w_ci = i_cin;
        end
    end

    assign w_sum = {1'b0, i_a} + {1'b0, w_bb} + {32'd0, w_ci};

    always_comb begin
        o_result  = 32'd0;
        w_c       = 1'b0;
        w_v       = 1'b0;
        o_flag_en = 4'b0000;
        case (i_funct)
            C_FN_NOT:  begin o_result = ~i_a;        o_flag_en = 4'b0101; end
            C_FN_AND:  begin o_result = i_a & i_b;   o_flag_en = 4'b0101; end
            C_FN_OR:   begin o_result = i_a | i_b;   o_flag_en = 4'b0101; end
            C_FN_XOR:  begin o_result = i_a ^ i_b;   o_flag_en = 4'b0101; end
            C_FN_PASS: begin o_result = i_b;         o_flag_en = 4'b0101; end
            C_FN_ADD, C_FN_SUB, C_FN_ADC: begin
                o_result  = w_sum[31:0];
                w_c       = w_sum[32];
                w_v       = (i_a[31] == w_bb[31]) && (w_sum[31] != i_a[31]);
                o_flag_en = 4'b1111;
            end
            C_FN_SHL: begin
                o_result  = i_a << w_sh;
                w_c       = w_lo[0];
                o_flag_en = 4'b1101;
            end
            C_FN_SHR: begin
                o_result  = i_a >> w_sh;
                w_c       = w_hi[31];
                o_flag_en = 4'b1101;
            end
`ifdef SISC_ROTATE_EN
            C_FN_ROL: begin
                o_result  = (i_a << w_sh) | w_lo;
                w_c       = w_lo[0];
                o_flag_en = 4'b1101;
            end
            C_FN_ROR: begin
                o_result  = (i_a >> w_sh) | w_hi;
                w_c       = w_hi[31];
                o_flag_en = 4'b1101;
            end
`endif
            default: ;
        endcase
    end

    always_comb begin
        o_flags          = 4'b0000;
        o_flags[C_STS_C] = w_c;
        o_flags[C_STS_N] = o_result[31];
        o_flags[C_STS_V] = w_v;
        o_flags[C_STS_Z] = (o_result == 32'd0);
    end

endmodule

`default_nettype wire

// File: rtl/sisc_exec_ctrl.sv
// ============================================================================
//  Module      : sisc_exec_ctrl
//  Description : SISC multicycle control FSM, ALU wrapper and branch target
//                unit. Optional macro: SISC_ROTATE_EN (enables ROL/ROR).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sisc_exec_ctrl
    import sisc_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        rst_f,
    sisc_exec_ctrl_if.slave  bus
);

    state_t      r_state;
    logic        r_pc_rst;
    logic        r_ir_load;
    logic        r_rf_we;

    logic [3:0]  w_opcode;
    logic [3:0]  w_mm;
    logic [15:0] w_imm;
    logic        w_is_alu;
    logic        w_taken;
    logic        w_br_go;
    logic [31:0] w_alu_b;
    logic [3:0]  w_flag_en;
    logic        w_unused;

    assign w_opcode = bus.instr[31:28];
    assign w_mm     = bus.instr[27:24];
    assign w_imm    = bus.instr[15:0];
    assign w_is_alu = (w_opcode == C_OP_ALU_RR) || (w_opcode == C_OP_ALU_RI);
    assign w_unused = &{1'b0, bus.instr[23:16]};

    assign w_alu_b  = (w_opcode == C_OP_ALU_RI) ? {{16{w_imm[15]}}, w_imm} : bus.regb;

    sisc_alu u_alu (
        .i_a       (bus.rega),
        .i_b       (w_alu_b),
        .i_funct   (w_mm),
        .i_cin     (bus.stat[C_STS_C]),
        .o_result  (bus.alu_out),
        .o_flags   (bus.alu_sts),
        .o_flag_en (w_flag_en)
    );

    always_comb begin
        w_taken = 1'b0;
        case (w_opcode)
            C_OP_BRA, C_OP_BRR: w_taken = (w_mm == 4'd0) || ((w_mm & bus.stat) != 4'd0);
            C_OP_BNE, C_OP_BNR: w_taken = ((w_mm & bus.stat) == 4'd0);
            default:            w_taken = 1'b0;
        endcase
    end

    assign bus.br_sel  = (w_opcode == C_OP_BRA) || (w_opcode == C_OP_BNE);
    assign bus.br_addr = bus.br_sel ? w_imm : (bus.pc_in + w_imm);

    always_ff @(posedge clk) begin
        if (rst_f) begin
            r_state   <= ST_START0;
            r_pc_rst  <= 1'b1;
            r_ir_load <= 1'b0;
            r_rf_we   <= 1'b0;
        end else begin
            r_pc_rst  <= 1'b0;
            r_ir_load <= 1'b0;
            r_rf_we   <= 1'b0;
            case (r_state)
                ST_START0:    r_state <= ST_START1;
                ST_START1: begin
                    r_state   <= ST_FETCH;
                    r_ir_load <= 1'b1;
                end
                ST_FETCH:     r_state <= ST_DECODE;
                ST_DECODE:    r_state <= (w_opcode == C_OP_HLT) ? ST_HALT : ST_EXECUTE;
                ST_EXECUTE:   r_state <= ST_MEM;
                ST_MEM: begin
                    r_state <= ST_WRITEBACK;
                    r_rf_we <= w_is_alu;
                end
                ST_WRITEBACK: begin
                    r_state   <= ST_FETCH;
                    r_ir_load <= 1'b1;
                end
                default:      r_state <= ST_HALT;
            endcase
        end
    end

    // Reset masks every write strobe immediately, even mid-instruction.
    assign w_br_go      = !rst_f && (r_state == ST_DECODE) && w_taken;
    assign bus.pc_rst   = rst_f || r_pc_rst;
    assign bus.ir_load  = !rst_f && r_ir_load;
    assign bus.rf_we    = !rst_f && r_rf_we;
    assign bus.wb_sel   = 1'b0;
    assign bus.pc_sel   = w_br_go;
    assign bus.pc_write = (!rst_f && r_ir_load) || w_br_go;
    assign bus.stat_en  = (!rst_f && (r_state == ST_EXECUTE) && w_is_alu) ? w_flag_en : 4'b0000;

endmodule

`default_nettype wire

// File: tb/tb_sisc_exec_ctrl.sv
// ============================================================================
//  Module      : tb_sisc_exec_ctrl
//  Description : Directed self-checking bench for sisc_exec_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sisc_exec_ctrl;

    logic clk = 1'b0;
    logic rst_f;
    int   checks = 0;
    int   errors = 0;
    int   bad;

    sisc_exec_ctrl_if u_if ();

    sisc_exec_ctrl u_dut (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; sample just after the falling edge.
    task automatic cyc;
        @(negedge clk);
        #1;
    endtask

    // Full five-cycle ALU instruction, entered with the next edge going to FETCH.
    task automatic run_alu(input string tag, input logic [31:0] ins, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] exp_out,
                           input logic [3:0] exp_sts, input logic [3:0] exp_en);
        u_if.instr = ins;
        u_if.rega  = a;
        u_if.regb  = b;
        cyc;  chk({tag, "_fetch_ir_load"}, u_if.ir_load, 1);
        cyc;  chk({tag, "_decode_pc_write"}, u_if.pc_write, 0);
        cyc;  chk({tag, "_alu_out"}, u_if.alu_out, exp_out);
              chk({tag, "_alu_sts"}, u_if.alu_sts, exp_sts);
              chk({tag, "_stat_en"}, u_if.stat_en, exp_en);
        cyc;  chk({tag, "_mem_stat_en"}, u_if.stat_en, 0);
        cyc;  chk({tag, "_wb_rf_we"}, u_if.rf_we, 1);
              chk({tag, "_wb_sel"}, u_if.wb_sel, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_f       = 1'b1;
        u_if.instr  = 32'd0;
        u_if.rega   = 32'd0;
        u_if.regb   = 32'd0;
        u_if.stat   = 4'd0;
        u_if.pc_in  = 16'd0;

        repeat (2) cyc;
        chk("rst_pc_rst",   u_if.pc_rst, 1);
        chk("rst_ir_load",  u_if.ir_load, 0);
        chk("rst_pc_write", u_if.pc_write, 0);
        chk("rst_rf_we",    u_if.rf_we, 0);
        chk("rst_stat_en",  u_if.stat_en, 0);
        chk("rst_pc_sel",   u_if.pc_sel, 0);
        chk("rst_br_sel",   u_if.br_sel, 0);

        rst_f = 1'b0;
        cyc;
        chk("start1_pc_rst",   u_if.pc_rst, 0);
        chk("start1_ir_load",  u_if.ir_load, 0);
        chk("start1_pc_write", u_if.pc_write, 0);

        run_alu("add_ovf", 32'h11312000, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 4'b0110, 4'b1111);
        run_alu("sub_zero", 32'h12312000, 32'h00000005, 32'h00000005, 32'h00000000, 4'b1001, 4'b1111);
        run_alu("or_imm", 32'h2531FFFF, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 4'b0100, 4'b0101);
        run_alu("shl_c", 32'h17312000, 32'h80000001, 32'h00000001, 32'h00000002, 4'b1000, 4'b1101);

        // BRR, relative, condition Z
        u_if.instr = 32'h51000005;
        u_if.pc_in = 16'h0010;
        u_if.stat  = 4'b0001;
        cyc;  chk("brr_fetch_pc_sel", u_if.pc_sel, 0);
        cyc;  chk("brr_br_sel",   u_if.br_sel, 0);
              chk("brr_br_addr",  u_if.br_addr, 32'h0015);
              chk("brr_pc_sel",   u_if.pc_sel, 1);
              chk("brr_pc_write", u_if.pc_write, 1);
        u_if.stat = 4'b0000;
        #1;   chk("brr_nt_pc_write", u_if.pc_write, 0);
        cyc;  chk("brr_exec_stat_en", u_if.stat_en, 0);
        cyc;
        cyc;  chk("brr_wb_rf_we", u_if.rf_we, 0);

        // BNE, absolute target
        u_if.instr = 32'h61000040;
        cyc;
        cyc;  chk("bne_br_sel",   u_if.br_sel, 1);
              chk("bne_br_addr",  u_if.br_addr, 32'h0040);
              chk("bne_pc_write", u_if.pc_write, 1);
              chk("bne_pc_sel",   u_if.pc_sel, 1);
        cyc;
        cyc;
        cyc;

        // ADD interrupted by reset during EXECUTE
        u_if.instr = 32'h11312000;
        u_if.rega  = 32'h7FFFFFFF;
        u_if.regb  = 32'h00000001;
        cyc;
        cyc;
        cyc;  chk("irq_exec_stat_en", u_if.stat_en, 4'b1111);
        rst_f = 1'b1;
        #1;   chk("irq_rst_stat_en", u_if.stat_en, 0);
              chk("irq_rst_pc_rst",  u_if.pc_rst, 1);
        cyc;  chk("irq_rf_we",   u_if.rf_we, 0);
              chk("irq_pc_rst",  u_if.pc_rst, 1);
        rst_f = 1'b0;
        cyc;  chk("irq_start1_rf_we", u_if.rf_we, 0);
              chk("irq_start1_pc_rst", u_if.pc_rst, 0);

        // HLT
        u_if.instr = 32'hF0000000;
        cyc;  chk("hlt_fetch_ir_load", u_if.ir_load, 1);
        cyc;  chk("hlt_decode_pc_write", u_if.pc_write, 0);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            cyc;
            if (u_if.ir_load || u_if.pc_write || u_if.rf_we || u_if.pc_rst || (u_if.stat_en != 4'd0))
                bad++;
        end
        chk("hlt_quiet", bad, 0);
        rst_f = 1'b1;
        cyc;  chk("hlt_rst_pc_rst", u_if.pc_rst, 1);
        rst_f = 1'b0;
        u_if.instr = 32'd0;
        cyc;  chk("restart_start1_ir_load", u_if.ir_load, 0);
        cyc;  chk("restart_fetch_ir_load", u_if.ir_load, 1);
              chk("restart_fetch_pc_write", u_if.pc_write, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
